ks_adder_pipe: RTL and testbench
================================

# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor. It extends the team's 8-bit combinational sum/carry adder with four additions: configurable width, add/sub/increment/decrement modes, a signed-overflow flag, and a valid/ready stream interface. One prefix level is registered per pipeline stage, so throughput is one operation per cycle. The block sits in the arithmetic datapath between stream producers and consumers.

## Interface
- `WIDTH`, default 8: operand width; power of two, 4..64.
- `LEVELS`, derived as clog2(WIDTH): number of prefix levels; not overridable.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B; ignored for op 10 and op 11.
- `cin`  in  1  carry-in (op 00) or borrow-in (op 01); ignored otherwise.
- `op`  in  2  operation: 00 A+B+cin; 01 A−B−cin; 10 A+1; 11 A−1.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `S`  out  WIDTH  result.
- `C`  out  1  carry-out; in op 01 and op 11 this is NOT borrow (1 = no borrow).
- `V`  out  1  two's-complement signed overflow.

## Operation
- Effective operands:
  - op 00: b_eff=B, c0=cin.
  - op 01: b_eff=~B, c0=~cin.
  - op 10: b_eff=0, c0=1.
  - op 11: b_eff=all ones, c0=0.
- c0 is folded in as generate at bit −1, so no separate carry-in adder is needed.
- Stage 0: p_i = A_i ^ b_eff_i, g_i = A_i & b_eff_i, registered together with c0 and A/b_eff MSBs.
- Stage k (k=1..LEVELS): for i ≥ 2^(k−1), G = G_i | (P_i & G_{i−2^(k−1)}) and P = P_i & P_{i−2^(k−1)}; lower bits pass through. Each stage is registered.
- Output stage:
  - S_i = p_i ^ carry_i, where carry_0=c0 and carry_i=G_{i−1}.
  - C = G_{WIDTH−1}.
  - V = carry_{WIDTH−1} ^ C.
  - Registered into S/C/V.
- Each stage holds a valid bit. Bubbles propagate and are not collapsed.
- Global stall: stall = out_valid & ~out_ready. While stalled, every stage register, including valid bits, holds.
- in_ready = ~stall & ~rst. This is combinational from out_ready; no other comb path exists from inputs to outputs.
- A beat is accepted when in_valid & in_ready at a rising edge. A result is consumed when out_valid & out_ready.
- Results leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: LEVELS+1 cycles. A beat accepted at edge N has out_valid high after edge N+LEVELS+1. WIDTH=8 gives 4 cycles; WIDTH=32 gives 6.
- Throughput: one beat per cycle while out_ready is held high.
- Reset values, applied at the first edge with rst high:
  - All valid bits are 0, so out_valid=0.
  - S=0, C=0, V=0.
  - Internal p/g registers are don't-care.
- Reset mid-operation: all in-flight beats are discarded; no result is emitted for them. A beat presented while rst is high is not accepted.
- First accept after reset: possible at the first edge with rst low.
- Stall entry and exit: out_ready low with out_valid high freezes S/C/V/out_valid on the next edge. Producer beats wait, since in_ready=0. When out_ready returns high, the held result is consumed and the pipeline advances on that same edge.
- out_valid low with out_ready low is not a stall; bubbles keep flowing.
- Wrap-around follows modulo 2^WIDTH. Example: A=all ones with op 10 gives S=0, C=1, V=0.

## Structure
- Package `ks_pkg`:
  - op encoding as a typedef: OP_ADD, OP_SUB, OP_INC, OP_DEC.
  - A clog2 function.
  - A helper function computing b_eff/c0 from op.
- Sub-module `ks_prefix_stage`: parameters WIDTH and DIST. It implements one registered prefix level with valid and stall, and is instantiated LEVELS times in a generate loop.
- The top level holds stage 0, the output stage, and the stall/ready logic.

## Test plan
All scenarios use WIDTH=8.
- Add: A=0x13, B=0x2A, op 00, cin 0 → S=0x3D, C=0, V=0, appearing 4 cycles after accept. Next, A=0xF0, B=0x12 → S=0x02, C=1. Next, A=0xAA, B=0xBD → S=0x67, C=1, V=1.
- Sub and overflow: A=0x65, B=0x64, op 01 → S=0x01, C=1. Next, A=0x00, B=0x01, op 01 → S=0xFF, C=0. Next, A=0x7F, B=0x01, op 00 → S=0x80, V=1.
- Inc/dec wrap: A=0xFF, op 10 → S=0x00, C=1. Next, A=0x00, op 11 → S=0xFF, C=0. Next, A=0x80, op 11 → S=0x7F, V=1.
- Streaming with backpressure: send 8 back-to-back random beats, pulling out_ready low for 3 cycles mid-stream → in_ready drops the same cycle, S/C/V hold steady, and all 8 results arrive in order and match the model.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → out_valid=0 and S=0 after that edge; none of the 3 results ever appear; a new beat accepted at the next edge returns 4 cycles later.
- Parameter sweep: WIDTH=4, 16, 32, 64, each with 1000 random ops against a reference model → zero mismatches, with latency LEVELS+1.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder/subtractor.
package ks_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } ks_op_e;

  // b_eff = (b_zero ? 0 : B), then inverted if b_inv; c0 is the folded carry-in
  typedef struct packed {
    logic b_zero;
    logic b_inv;
    logic c0;
  } ks_ctl_t;

  function automatic int ks_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic ks_ctl_t ks_op_ctl(input ks_op_e op, input logic cin);
    ks_ctl_t c;
    case (op)
      OP_ADD:  c = '{b_zero: 1'b0, b_inv: 1'b0, c0: cin};
      OP_SUB:  c = '{b_zero: 1'b0, b_inv: 1'b1, c0: ~cin};
      OP_INC:  c = '{b_zero: 1'b1, b_inv: 1'b0, c0: 1'b1};
      default: c = '{b_zero: 1'b1, b_inv: 1'b1, c0: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
// One registered Kogge-Stone prefix level; sum-propagate and carry-in ride along.
module ks_prefix_stage #(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_x,
  input  logic             in_c0,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_g,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_x,
  output logic             out_c0
);

  logic [WIDTH-1:0] g_n, p_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_comb
      assign g_n[i] = in_g[i] | (in_p[i] & in_g[i-DIST]);
      assign p_n[i] = in_p[i] & in_p[i-DIST];
    end else begin : g_pass
      assign g_n[i] = in_g[i];
      assign p_n[i] = in_p[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
    end else if (!stall) begin
      out_vld <= in_vld;
      out_g   <= g_n;
      out_p   <= p_n;
      out_x   <= in_x;
      out_c0  <= in_c0;
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/sub/inc/dec with valid/ready stream and global stall.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int LEVELS = ks_clog2(WIDTH);

  logic stall;
  logic [LEVELS:0]            vld_pipe, c0_pipe;
  logic [LEVELS:0][WIDTH-1:0] g_pipe, p_pipe, x_pipe;

  ks_ctl_t          ctl;
  logic [WIDTH-1:0] b_eff, g0;
  logic             s0_vld, s0_c0;
  logic [WIDTH-1:0] s0_g, s0_p;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~rst;

  // Carry-in is absorbed into bit 0's generate, so the prefix tree never needs a
  // separate carry-in term and G_i is the true carry out of bit i.
  always_comb begin
    ctl   = ks_op_ctl(ks_op_e'(op), cin);
    b_eff = ctl.b_zero ? '0 : B;
    if (ctl.b_inv) b_eff = ~b_eff;
    g0    = A & b_eff;
    g0[0] = g0[0] | ((A[0] ^ b_eff[0]) & ctl.c0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld <= 1'b0;
    end else if (!stall) begin
      s0_vld <= in_valid & in_ready;
      s0_g   <= g0;
      s0_p   <= A ^ b_eff;
      s0_c0  <= ctl.c0;
    end
  end

  assign vld_pipe[0] = s0_vld;
  assign g_pipe[0]   = s0_g;
  assign p_pipe[0]   = s0_p;
  assign x_pipe[0]   = s0_p;
  assign c0_pipe[0]  = s0_c0;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    ks_prefix_stage #(.WIDTH(WIDTH), .DIST(1 << (k-1))) u_stage (
      .clk    (clk),
      .rst    (rst),
      .stall  (stall),
      .in_vld (vld_pipe[k-1]),
      .in_g   (g_pipe[k-1]),
      .in_p   (p_pipe[k-1]),
      .in_x   (x_pipe[k-1]),
      .in_c0  (c0_pipe[k-1]),
      .out_vld(vld_pipe[k]),
      .out_g  (g_pipe[k]),
      .out_p  (p_pipe[k]),
      .out_x  (x_pipe[k]),
      .out_c0 (c0_pipe[k])
    );
  end

  logic [WIDTH-1:0] carry;
  assign carry = {g_pipe[LEVELS][WIDTH-2:0], c0_pipe[LEVELS]};

  // Result registers only load real beats, so S stays 0 after reset until one lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      S         <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
    end else if (!stall) begin
      out_valid <= vld_pipe[LEVELS];
      if (vld_pipe[LEVELS]) begin
        S <= x_pipe[LEVELS] ^ carry;
        C <= g_pipe[LEVELS][WIDTH-1];
        V <= carry[WIDTH-1] ^ g_pipe[LEVELS][WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: 8-bit directed/stall/reset traffic plus a 32-bit random stream.
module tb_ks_adder_pipe;

  typedef struct packed {
    logic        v;
    logic        c;
    logic [63:0] s;
  } res_t;

  typedef struct {
    res_t exp;
    int   acc;
    int   stl;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid, in_ready, cin, out_valid, out_ready, C, V;
  logic [7:0] A, B, S;
  logic [1:0] op;

  logic        iv32, ir32, cin32, ov32, or32, c32, v32;
  logic [31:0] a32, b32, s32;
  logic [1:0]  op32;

  ks_adder_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .C(C), .V(V)
  );

  ks_adder_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .cin(cin32), .op(op32),
    .out_valid(ov32), .out_ready(or32), .S(s32), .C(c32), .V(v32)
  );

  int tests = 0, fails = 0, cyc = 0, stl8 = 0, stl32 = 0;
  ent_t q8[$], q32[$];

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Arithmetic reference: exact integer results, then reduced modulo 2^w.
  function automatic res_t model(input int w, input logic [1:0] o, input longint a,
                                 input longint b, input logic ci);
    res_t   r;
    longint m, half, sa, sb, u, sr;
    m    = 64'sd1 <<< w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    r    = '0;
    case (o)
      2'b00: begin u = a + b + longint'(ci); sr = sa + sb + longint'(ci); r.c = (u >= m); end
      2'b01: begin u = a - b - longint'(ci); sr = sa - sb - longint'(ci); r.c = (u >= 0); end
      2'b10: begin u = a + 1; sr = sa + 1; r.c = (u >= m); end
      default: begin u = a - 1; sr = sa - 1; r.c = (u >= 0); end
    endcase
    r.s = 64'(((u % m) + m) % m);
    r.v = (sr >= half) || (sr < -half);
    return r;
  endfunction

  logic        prev_rst = 1'b0, pst8 = 1'b0, pst32 = 1'b0;
  logic [7:0]  hs8;
  logic        hc8, hv8, hc32, hv32;
  logic [31:0] hs32;

  // Sampled at negedge; "edge n" is the rising edge following negedge n.
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (prev_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_S", S, 0);
      chk("rst_C", C, 0);
      chk("rst_V", V, 0);
      chk("rst_out_valid32", ov32, 0);
      chk("rst_S32", s32, 0);
    end
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      q8.delete();
      q32.delete();
      pst8  = 1'b0;
      pst32 = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (pst8) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_S", S, hs8);
        chk("hold_CV", {C, V}, {hc8, hv8});
      end
      if (in_valid && in_ready) begin
        e.exp = model(8, op, longint'(A), longint'(B), cin);
        e.acc = cyc;
        e.stl = stl8;
        q8.push_back(e);
      end
      if (out_valid && out_ready) begin
        chk("result_queued", q8.size() > 0, 1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("S", S, e.exp.s);
          chk("C", C, e.exp.c);
          chk("V", V, e.exp.v);
          chk("latency", (cyc - 1) - e.acc, 4 + stl8 - e.stl);
        end
      end
      pst8 = out_valid && !out_ready;
      if (pst8) stl8++;
      hs8 = S; hc8 = C; hv8 = V;

      chk("in_ready32", ir32, !(ov32 && !or32));
      if (pst32) begin
        chk("hold_valid32", ov32, 1);
        chk("hold_S32", s32, hs32);
        chk("hold_CV32", {c32, v32}, {hc32, hv32});
      end
      if (iv32 && ir32) begin
        e.exp = model(32, op32, longint'(a32), longint'(b32), cin32);
        e.acc = cyc;
        e.stl = stl32;
        q32.push_back(e);
      end
      if (ov32 && or32) begin
        chk("result_queued32", q32.size() > 0, 1);
        if (q32.size() > 0) begin
          e = q32.pop_front();
          chk("S32", s32, e.exp.s);
          chk("C32", c32, e.exp.c);
          chk("V32", v32, e.exp.v);
          chk("latency32", (cyc - 1) - e.acc, 6 + stl32 - e.stl);
        end
      end
      pst32 = ov32 && !or32;
      if (pst32) stl32++;
      hs32 = s32; hc32 = c32; hv32 = v32;
    end
    prev_rst = rst;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [1:0] o);
    logic ok;
    A = a; B = b; cin = ci; op = o; in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("accept", ok, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Literal expectations pin the model before the beat goes to the DUT.
  task automatic send_lit(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [1:0] o, input logic [7:0] es, input logic ec,
                          input logic ev);
    res_t r;
    r = model(8, o, longint'(a), longint'(b), ci);
    chk("model_S", r.s, es);
    chk("model_C", r.c, ec);
    chk("model_V", r.v, ev);
    send(a, b, ci, o);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q8.size() != 0 || q32.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain", q8.size() + q32.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input int n);
    int   sent;
    logic acc;
    sent = 0;
    a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); op32 = 2'($urandom);
    iv32 = 1'b1;
    for (int t = 0; t < 4000 && sent < n; t++) begin
      @(negedge clk);
      acc = ir32;
      if (acc) sent++;
      @(posedge clk);
      #1;
      if (acc) begin
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); op32 = 2'($urandom);
      end
      or32 = ($urandom_range(3) != 0);
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    chk("sent32", sent, n);
  endtask

  initial begin
    int s0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; cin = 1'b0; op = 2'b00;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; op32 = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send_lit(8'h13, 8'h2A, 1'b0, 2'b00, 8'h3D, 1'b0, 1'b0);
    send_lit(8'hF0, 8'h12, 1'b0, 2'b00, 8'h02, 1'b1, 1'b0);
    send_lit(8'hAA, 8'hBD, 1'b0, 2'b00, 8'h67, 1'b1, 1'b1);
    send_lit(8'h65, 8'h64, 1'b0, 2'b01, 8'h01, 1'b1, 1'b0);
    send_lit(8'h00, 8'h01, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b0);
    send_lit(8'h7F, 8'h01, 1'b0, 2'b00, 8'h80, 1'b0, 1'b1);
    send_lit(8'hFF, 8'h5A, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0);
    send_lit(8'h00, 8'h33, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
    send_lit(8'h80, 8'h00, 1'b0, 2'b11, 8'h7F, 1'b1, 1'b1);
    send_lit(8'h10, 8'h05, 1'b1, 2'b01, 8'h0A, 1'b1, 1'b0);
    send_lit(8'hFF, 8'h00, 1'b1, 2'b00, 8'h00, 1'b1, 1'b0);
    send_lit(8'h7F, 8'h55, 1'b0, 2'b10, 8'h80, 1'b0, 1'b1);
    drain();

    // Back-to-back beats with a 3-cycle consumer stall while results are flowing
    s0 = stl8;
    fork
      for (int i = 0; i < 8; i++)
        send(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", stl8 - s0, 3);

    // Reset with three beats in flight; a beat offered during reset waits
    for (int i = 0; i < 3; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
    rst = 1'b1;
    A = 8'h21; B = 8'h10; cin = 1'b0; op = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send_lit(8'h21, 8'h10, 1'b0, 2'b00, 8'h31, 1'b0, 1'b0);
    drain();

    run32(300);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
